wb_grf: RTL and testbench
=========================

WB_GRF -- requirements
Module: wb_grf

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset (reset=0 resets on the next rising clk edge).
REQ-003 The block SHALL have ports W_IF, W_PCadd4, W_ALUout and W_DMout, each input, 32 bits: writeback-stage instruction word, PC+4, ALU result and data-memory read data.
REQ-004 The block SHALL have ports W_A3sel and W_WDsel, each input, 2 bits: destination-register select and write-data select.
REQ-005 The block SHALL have port W_GRFEn, input, 1 bit: register-write enable for the instruction in writeback.
REQ-006 The block SHALL have ports D_A1 and D_A2, each input, 5 bits: decode-stage read addresses.
REQ-007 The block SHALL have ports RD1 and RD2, each output, 32 bits: read data for D_A1 and D_A2.
REQ-008 The block SHALL have port W_A3, output, 5 bits: resolved destination register, for the hazard and forwarding unit.
REQ-009 The block SHALL have port W_WD, output, 32 bits: resolved write data, for forwarding.
REQ-010 The block SHALL have port W_WE, output, 1 bit: effective write strobe, 1 when a register actually changes this cycle.
REQ-011 The block SHALL have port wb_count, output, 32 bits: count of retired effective writes.

Function
REQ-012 W_A3 SHALL decode W_A3sel as: 0 = W_IF[20:16] (rt); 1 = W_IF[15:11] (rd); 2 = 5'd31; 3 = 5'd0.
REQ-013 W_WD SHALL decode W_WDsel as: 0 = W_ALUout; 1 = W_DMout; 2 = W_PCadd4+4 (modulo 2^32, for link); 3 = 32'd0.
REQ-014 W_WE SHALL equal W_GRFEn & (W_A3 != 0) & reset, combinationally.
REQ-015 On a rising edge with W_WE=1, the block SHALL write register[W_A3] <= W_WD; no other register changes.
REQ-016 Register 0 SHALL always read 0; writes to register 0 SHALL be discarded and SHALL NOT be counted.
REQ-017 RDn SHALL be combinational: 0 if D_An=0; else W_WD if W_WE=1 and D_An=W_A3 (internal bypass, write-before-read); else register[D_An].
REQ-018 Both read ports SHALL bypass independently; D_A1=D_A2=W_A3 SHALL return W_WD on both ports.
REQ-019 wb_count SHALL increment by 1 on each rising edge with W_WE=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-020 Write latency SHALL be one edge: a value written at edge N SHALL be readable from storage after edge N, and from the bypass during the cycle before edge N.
REQ-021 The block SHALL have no stall or flush inputs; an upstream bubble is represented by W_GRFEn=0.

Reset
REQ-022 When reset=0 at a rising edge, all 32 registers and wb_count SHALL become 0.
REQ-023 Reset SHALL dominate a simultaneous write: no register is written and no count is taken.
REQ-024 While reset=0, W_WE SHALL be 0 and the bypass SHALL be disabled, so RDn returns the stored value.
REQ-025 W_A3 and W_WD SHALL remain pure decodes of the inputs during reset.

Structure
REQ-026 A shared package SHALL hold the A3SEL_RT/RD/RA/NONE encodings (0-3), the WDSEL_ALU/DM/PC8/ZERO encodings (0-3), and the register-count constant 32.
REQ-027 Storage SHALL be one sub-module, grf_array: 32x32 storage with one write port and two async read ports, register 0 forced to zero, and synchronous active-low clear.
REQ-028 The select decode, bypass logic and counter SHALL reside in wb_grf.

Verification
REQ-029 The bench SHALL apply reset=0 for 2 edges, then read all 32 addresses, and SHALL require 0 on all reads and wb_count=0.
REQ-030 The bench SHALL apply W_IF=0x00851020 (rd=2), W_A3sel=1, W_WDsel=0, W_ALUout=0x12345678, W_GRFEn=1, D_A1=2, and SHALL require RD1=0x12345678 before the edge (bypass), W_A3=2, and after the edge register 2=0x12345678 with wb_count=1.
REQ-031 The bench SHALL apply W_A3sel=2, W_WDsel=2, W_PCadd4=0x00003004, W_GRFEn=1, and SHALL require W_A3=31, W_WD=0x00003008, and register 31=0x00003008 after the edge.
REQ-032 The bench SHALL apply W_IF rt=0, W_A3sel=0, W_GRFEn=1, W_ALUout=0xFFFFFFFF, D_A1=0, and SHALL require W_WE=0, RD1=0, register 0 still 0, and wb_count unchanged.
REQ-033 The bench SHALL apply a write to register 5 with data 0xABCD in the same cycle as reset=0, and SHALL require register 5=0 after the edge and wb_count=0.
REQ-034 The bench SHALL preload wb_count to 0xFFFFFFFF through a hierarchical force, then perform one effective write, and SHALL require wb_count=0.

Source files
------------

// File: rtl/wb_grf_pkg.sv
// Shared encodings and sizes for the writeback-stage general register file.
// Select fields come straight from the decoder as 2-bit codes.
package wb_grf_pkg;

   localparam int NUM_REGS = 32;
   localparam int XLEN     = 32;
   localparam int AW       = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      A3SEL_RT   = 2'd0,
      A3SEL_RD   = 2'd1,
      A3SEL_RA   = 2'd2,
      A3SEL_NONE = 2'd3
   } a3sel_e;

   typedef enum logic [1:0] {
      WDSEL_ALU  = 2'd0,
      WDSEL_DM   = 2'd1,
      WDSEL_PC8  = 2'd2,
      WDSEL_ZERO = 2'd3
   } wdsel_e;

endpackage

// File: rtl/grf_array.sv
// 32x32 register storage: one write port, two asynchronous read ports.
// Register 0 has no storage and always reads zero.
module grf_array
   import wb_grf_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n_i,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [AW-1:0]   raddr1_i,
   input  logic [AW-1:0]   raddr2_i,
   output logic [XLEN-1:0] rdata1_o,
   output logic [XLEN-1:0] rdata2_o
);

   logic [XLEN-1:0] mem_q [1:NUM_REGS-1];

   genvar gi;
   generate
      for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (!rst_n_i) begin
               mem_q[gi] <= '0;
            end else if (we_i && (waddr_i == AW'(gi))) begin
               mem_q[gi] <= wdata_i;
            end
         end
      end
   endgenerate

   always_comb begin
      rdata1_o = '0;
      rdata2_o = '0;
      if (raddr1_i != '0) rdata1_o = mem_q[raddr1_i];
      if (raddr2_i != '0) rdata2_o = mem_q[raddr2_i];
   end

endmodule

// File: rtl/wb_grf.sv
// Writeback-stage register file: destination/data select decode, internal
// write-before-read bypass, and a count of retired register writes.
module wb_grf
   import wb_grf_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] W_IF,
   input  logic [XLEN-1:0] W_PCadd4,
   input  logic [XLEN-1:0] W_ALUout,
   input  logic [XLEN-1:0] W_DMout,
   input  logic [1:0]      W_A3sel,
   input  logic [1:0]      W_WDsel,
   input  logic            W_GRFEn,
   input  logic [AW-1:0]   D_A1,
   input  logic [AW-1:0]   D_A2,
   output logic [XLEN-1:0] RD1,
   output logic [XLEN-1:0] RD2,
   output logic [AW-1:0]   W_A3,
   output logic [XLEN-1:0] W_WD,
   output logic            W_WE,
   output logic [XLEN-1:0] wb_count
);

   logic [XLEN-1:0] store_rd1;
   logic [XLEN-1:0] store_rd2;
   logic [XLEN-1:0] wb_count_q;
   logic [XLEN-1:0] wb_count_d;

   always_comb begin
      W_A3 = '0;
      case (a3sel_e'(W_A3sel))
         A3SEL_RT:   W_A3 = W_IF[20:16];
         A3SEL_RD:   W_A3 = W_IF[15:11];
         A3SEL_RA:   W_A3 = AW'(NUM_REGS - 1);
         A3SEL_NONE: W_A3 = '0;
         default:    W_A3 = '0;
      endcase
   end

   // Link value is the address after the delay slot, hence PC+8.
   always_comb begin
      W_WD = '0;
      case (wdsel_e'(W_WDsel))
         WDSEL_ALU:  W_WD = W_ALUout;
         WDSEL_DM:   W_WD = W_DMout;
         WDSEL_PC8:  W_WD = W_PCadd4 + XLEN'(4);
         WDSEL_ZERO: W_WD = '0;
         default:    W_WD = '0;
      endcase
   end

   // Reset gates the strobe, which also disables the bypass and the count.
   assign W_WE = W_GRFEn & (W_A3 != '0) & reset;

   grf_array u_grf_array (
      .clk      (clk),
      .rst_n_i  (reset),
      .we_i     (W_WE),
      .waddr_i  (W_A3),
      .wdata_i  (W_WD),
      .raddr1_i (D_A1),
      .raddr2_i (D_A2),
      .rdata1_o (store_rd1),
      .rdata2_o (store_rd2)
   );

   always_comb begin
      RD1 = store_rd1;
      RD2 = store_rd2;
      if (W_WE && (D_A1 == W_A3)) RD1 = W_WD;
      if (W_WE && (D_A2 == W_A3)) RD2 = W_WD;
   end

   assign wb_count_d = W_WE ? wb_count_q + XLEN'(1) : wb_count_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_count_q <= '0;
      end else begin
         wb_count_q <= wb_count_d;
      end
   end

   assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed scenarios plus randomized
// writeback traffic compared against an array-based register model.
module tb_wb_grf;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] W_IF, W_PCadd4, W_ALUout, W_DMout;
   logic [1:0]  W_A3sel, W_WDsel;
   logic        W_GRFEn;
   logic [4:0]  D_A1, D_A2;
   logic [31:0] RD1, RD2;
   logic [4:0]  W_A3;
   logic [31:0] W_WD;
   logic        W_WE;
   logic [31:0] wb_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_count;

   always #5 clk = ~clk;

   wb_grf dut (
      .clk      (clk),
      .reset    (reset),
      .W_IF     (W_IF),
      .W_PCadd4 (W_PCadd4),
      .W_ALUout (W_ALUout),
      .W_DMout  (W_DMout),
      .W_A3sel  (W_A3sel),
      .W_WDsel  (W_WDsel),
      .W_GRFEn  (W_GRFEn),
      .D_A1     (D_A1),
      .D_A2     (D_A2),
      .RD1      (RD1),
      .RD2      (RD2),
      .W_A3     (W_A3),
      .W_WD     (W_WD),
      .W_WE     (W_WE),
      .wb_count (wb_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] exp_a3();
      case (W_A3sel)
         2'd0:    return W_IF[20:16];
         2'd1:    return W_IF[15:11];
         2'd2:    return 5'd31;
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [31:0] exp_wd();
      case (W_WDsel)
         2'd0:    return W_ALUout;
         2'd1:    return W_DMout;
         2'd2:    return W_PCadd4 + 32'd4;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic exp_we();
      return W_GRFEn && (exp_a3() != 5'd0) && reset;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (exp_we() && a == exp_a3()) return exp_wd();
      return m_regs[a];
   endfunction

   // Inputs are already driven (after a negedge); check, take one edge, update model.
   task automatic step(input string tag);
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        we;
      #1;
      a3 = exp_a3();
      wd = exp_wd();
      we = exp_we();
      check({tag, ".W_A3"}, 32'(W_A3), 32'(a3));
      check({tag, ".W_WD"}, W_WD, wd);
      check({tag, ".W_WE"}, 32'(W_WE), 32'(we));
      check({tag, ".RD1"}, RD1, exp_rd(D_A1));
      check({tag, ".RD2"}, RD2, exp_rd(D_A2));
      check({tag, ".wb_count"}, wb_count, m_count);
      $display("txn %s: rst=%0b en=%0b a3=%0d wd=0x%08h we=%0b cnt=%0d", tag, reset, W_GRFEn, a3, wd, we, m_count);
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_count = 32'd0;
      end else if (we) begin
         m_regs[a3] = wd;
         m_count    = m_count + 32'd1;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      W_GRFEn = 1'b0;
      W_A3sel = 2'd3;
      W_WDsel = 2'd3;
   endtask

   task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
      idle();
      D_A1 = a;
      D_A2 = a;
      #1;
      check({tag, ".RD1"}, RD1, exp);
      check({tag, ".RD2"}, RD2, exp);
   endtask

   initial begin
      reset = 1'b0; W_IF = '0; W_PCadd4 = '0; W_ALUout = '0; W_DMout = '0;
      W_A3sel = 2'd3; W_WDsel = 2'd3; W_GRFEn = 1'b0; D_A1 = '0; D_A2 = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;

      // Reset for two edges, then every address must read zero.
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         D_A1 = 5'(i);
         D_A2 = 5'(31 - i);
         #1;
         check($sformatf("rst_rd1[%0d]", i), RD1, 32'd0);
         check($sformatf("rst_rd2[%0d]", 31 - i), RD2, 32'd0);
      end
      check("rst_count", wb_count, 32'd0);
      $display("txn reset: all registers read back");

      // rd-type write with bypass before the edge.
      W_IF = 32'h0085_1020; W_A3sel = 2'd1; W_WDsel = 2'd0; W_ALUout = 32'h1234_5678;
      W_GRFEn = 1'b1; D_A1 = 5'd2; D_A2 = 5'd2;
      #1;
      check("byp_rd1", RD1, 32'h1234_5678);
      check("byp_rd2", RD2, 32'h1234_5678);
      check("byp_a3", 32'(W_A3), 32'd2);
      step("alu_rd");
      read_check("store_r2", 5'd2, 32'h1234_5678);
      check("count_1", wb_count, 32'd1);

      // Link write to r31.
      W_A3sel = 2'd2; W_WDsel = 2'd2; W_PCadd4 = 32'h0000_3004; W_GRFEn = 1'b1;
      D_A1 = 5'd31; D_A2 = 5'd0;
      #1;
      check("link_a3", 32'(W_A3), 32'd31);
      check("link_wd", W_WD, 32'h0000_3008);
      step("link");
      read_check("store_r31", 5'd31, 32'h0000_3008);

      // Write to r0 is discarded and not counted.
      W_IF = 32'h0300_F800; W_A3sel = 2'd0; W_WDsel = 2'd0; W_ALUout = 32'hFFFF_FFFF;
      W_GRFEn = 1'b1; D_A1 = 5'd0; D_A2 = 5'd0;
      #1;
      check("r0_we", 32'(W_WE), 32'd0);
      check("r0_rd1", RD1, 32'd0);
      step("r0_write");
      read_check("store_r0", 5'd0, 32'd0);
      check("r0_count", wb_count, 32'd2);

      // Randomized traffic with occasional reset pulses.
      for (int n = 0; n < 300; n++) begin
         reset    = ($urandom_range(0, 39) != 0);
         W_IF     = $urandom;
         W_PCadd4 = $urandom;
         W_ALUout = $urandom;
         W_DMout  = $urandom;
         W_A3sel  = 2'($urandom_range(0, 3));
         W_WDsel  = 2'($urandom_range(0, 3));
         W_GRFEn  = ($urandom_range(0, 3) != 0);
         D_A1     = ($urandom_range(0, 2) == 0) ? exp_a3() : 5'($urandom);
         D_A2     = ($urandom_range(0, 2) == 0) ? exp_a3() : 5'($urandom);
         step($sformatf("rnd%0d", n));
      end
      reset = 1'b1;
      for (int i = 0; i < 32; i++) read_check($sformatf("rnd_final[%0d]", i), 5'(i), m_regs[i]);

      // Reset dominates a simultaneous write to r5.
      reset = 1'b0; W_IF = 32'h0000_2800; W_A3sel = 2'd1; W_WDsel = 2'd0;
      W_ALUout = 32'h0000_ABCD; W_GRFEn = 1'b1; D_A1 = 5'd5; D_A2 = 5'd5;
      #1;
      check("rstw_a3", 32'(W_A3), 32'd5);
      check("rstw_wd", W_WD, 32'h0000_ABCD);
      check("rstw_we", 32'(W_WE), 32'd0);
      check("rstw_nobyp", RD1, m_regs[5]);
      step("rst_write");
      reset = 1'b1;
      read_check("rstw_r5", 5'd5, 32'd0);
      check("rstw_count", wb_count, 32'd0);

      // Counter wrap from all-ones.
      force dut.wb_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.wb_count_q;
      #1;
      check("wrap_pre", wb_count, 32'hFFFF_FFFF);
      m_count = 32'hFFFF_FFFF;
      W_IF = 32'h0007_0000; W_A3sel = 2'd0; W_WDsel = 2'd1; W_DMout = 32'hCAFE_0007;
      W_GRFEn = 1'b1; D_A1 = 5'd7; D_A2 = 5'd1;
      step("wrap");
      check("wrap_count", wb_count, 32'd0);
      read_check("wrap_r7", 5'd7, 32'hCAFE_0007);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
